branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_types_pkg.sv | 22 ++
 rtl/bp_sat_ctr.sv | 22 ++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bp_types_pkg.sv
// Shared types for the branch predictor: default BTB depth, 2-bit counter
// states and the BTB entry layout.
package bp_types_pkg;

  localparam int BP_ENTRIES = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bp_ctr_t;

  // tag holds pc >> IDX zero-extended, so one layout serves every ENTRIES value
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    bp_ctr_t     ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating direction counter: step toward taken or not-taken,
// holding at STRONG_T / STRONG_NT.
module bp_sat_ctr
  import bp_types_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      STRONG_NT: ctr_o = taken_i ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   ctr_o = taken_i ? WEAK_T   : STRONG_NT;
      WEAK_T:    ctr_o = taken_i ? STRONG_T : WEAK_NT;
      STRONG_T:  ctr_o = taken_i ? STRONG_T : WEAK_T;
      default:   ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, update from EX.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor
  import bp_types_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        lookup_en,
  input  logic [29:0] pc_i,
  output logic        phit_o,
  output logic [29:0] bp_addr_o,
  input  logic        upd_en,
  input  logic [29:0] upd_pc,
  input  logic        upd_taken,
  input  logic [29:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] lookup_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX = $clog2(ENTRIES);

  bp_entry_t      tbl_q [ENTRIES];
  bp_entry_t      tbl_d [ENTRIES];
  bp_entry_t      lk_ent, up_ent;
  logic [IDX-1:0] lk_idx, up_idx;
  logic           lk_hit, up_hit;
  bp_ctr_t        ctr_nxt;

  // Lookup reads the registered table only, so a same-cycle update is not seen
  assign lk_idx    = pc_i[IDX-1:0];
  assign lk_ent    = tbl_q[lk_idx];
  assign lk_hit    = lk_ent.valid && (lk_ent.tag == (pc_i >> IDX));
  assign phit_o    = lk_hit && lk_ent.ctr[1];
  assign bp_addr_o = phit_o ? lk_ent.target : pc_i + 30'd1;

  assign up_idx = upd_pc[IDX-1:0];
  assign up_ent = tbl_q[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == (upd_pc >> IDX));

  bp_sat_ctr u_sat (
    .ctr_i   (up_ent.ctr),
    .taken_i (upd_taken),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    tbl_d = tbl_q;
    if (upd_en) begin
      if (up_hit) begin
        tbl_d[up_idx].ctr = ctr_nxt;
        if (upd_taken) tbl_d[up_idx].target = upd_target;
      end else if (upd_taken) begin
        tbl_d[up_idx] = '{valid: 1'b1, tag: upd_pc >> IDX,
                          target: upd_target, ctr: WEAK_T};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    lookup_cnt_d     = lookup_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (lookup_en && lookup_cnt_q != '1)
      lookup_cnt_d = lookup_cnt_q + 32'd1;
    if (upd_en && upd_mispredict && mispredict_cnt_q != '1)
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      lookup_cnt_q     <= lookup_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign lookup_cnt_o     = lookup_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  logic unused_stats;
  assign unused_stats     = lookup_en ^ upd_mispredict;
  assign lookup_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16); stats expectations
// follow whether BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        lookup_en;
  logic [29:0] pc_i;
  logic        phit_o;
  logic [29:0] bp_addr_o;
  logic        upd_en;
  logic [29:0] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] lookup_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .lookup_en        (lookup_en),
    .pc_i             (pc_i),
    .phit_o           (phit_o),
    .bp_addr_o        (bp_addr_o),
    .upd_en           (upd_en),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .lookup_cnt_o     (lookup_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [29:0] pc, input logic tk,
                     input logic [29:0] tgt, input logic misp);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_mispredict = misp;
    tick();
    upd_en = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input string tag, input logic [29:0] pc,
                      input logic ph, input logic [29:0] addr);
    pc_i = pc;
    #1;
    check({tag, ".phit"}, {31'd0, phit_o}, {31'd0, ph});
    check({tag, ".addr"}, {2'd0, bp_addr_o}, {2'd0, addr});
  endtask

  initial begin
    // Reset cycles carry a taken update, a mispredict and a lookup; all discarded
    RST = 1'b1; lookup_en = 1'b1; pc_i = 30'h40;
    upd_en = 1'b1; upd_pc = 30'h40; upd_taken = 1'b1; upd_target = 30'h300;
    upd_mispredict = 1'b1;
    tick(); tick();
    RST = 1'b0; lookup_en = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;

    look("rst_lookup", 30'h40, 1'b0, 30'h41);
    check("rst_lcnt", lookup_cnt_o, 32'd0);
    check("rst_mcnt", mispredict_cnt_o, 32'd0);

    upd(30'h40, 1'b1, 30'h100, 1'b0);          // alloc, ctr=2
    look("alloc", 30'h40, 1'b1, 30'h100);
    upd(30'h40, 1'b0, 30'h0, 1'b0);            // ctr=1
    look("nt1", 30'h40, 1'b0, 30'h41);
    upd(30'h40, 1'b0, 30'h0, 1'b0);            // ctr=0
    look("nt2", 30'h40, 1'b0, 30'h41);
    upd(30'h40, 1'b0, 30'h0, 1'b0);            // stays 0
    look("nt3", 30'h40, 1'b0, 30'h41);
    upd(30'h40, 1'b1, 30'h100, 1'b0);          // 0->1 proves no wrap to 3
    look("t_from0", 30'h40, 1'b0, 30'h41);
    upd(30'h40, 1'b1, 30'h100, 1'b0);          // 1->2
    look("t_to2", 30'h40, 1'b1, 30'h100);
    upd(30'h40, 1'b1, 30'h120, 1'b0);          // 2->3, new target
    look("t_to3", 30'h40, 1'b1, 30'h120);
    upd(30'h40, 1'b1, 30'h120, 1'b0);          // holds 3
    upd(30'h40, 1'b0, 30'h0, 1'b0);            // 3->2, still taken
    look("sat_hi", 30'h40, 1'b1, 30'h120);

    // Same-cycle lookup and update: old prediction now, new one next cycle
    pc_i = 30'h40;
    upd_en = 1'b1; upd_pc = 30'h40; upd_taken = 1'b0; upd_target = 30'h0;
    upd_mispredict = 1'b1;
    #1;
    check("same_cyc.phit", {31'd0, phit_o}, 32'd1);
    check("same_cyc.addr", {2'd0, bp_addr_o}, 32'h120);
    tick();
    upd_en = 1'b0; upd_mispredict = 1'b0;
    look("next_cyc", 30'h40, 1'b0, 30'h41);

    upd(30'h50, 1'b1, 30'h200, 1'b0);          // alias replaces 0x40
    look("alias_old", 30'h40, 1'b0, 30'h41);
    look("alias_new", 30'h50, 1'b1, 30'h200);

    upd(30'h60, 1'b0, 30'h0, 1'b1);            // NT miss, second mispredict
    look("ntmiss_keep", 30'h50, 1'b1, 30'h200);
    look("ntmiss_none", 30'h60, 1'b0, 30'h61);
    look("pc_wrap", 30'h3FFFFFFF, 1'b0, 30'h0);

    // Mispredict flag without upd_en must not count
    upd_mispredict = 1'b1; tick(); upd_mispredict = 1'b0;

    lookup_en = 1'b1;
    repeat (5) tick();
    lookup_en = 1'b0;
    tick();
`ifdef BP_STATS_EN
    check("lookup_cnt", lookup_cnt_o, 32'd5);
    check("mispredict_cnt", mispredict_cnt_o, 32'd2);
`else
    check("lookup_cnt", lookup_cnt_o, 32'd0);
    check("mispredict_cnt", mispredict_cnt_o, 32'd0);
`endif

    // Reset clears a live entry and the statistics
    RST = 1'b1; tick(); RST = 1'b0;
    look("rst2", 30'h50, 1'b0, 30'h51);
    check("rst2_lcnt", lookup_cnt_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
